// File: rtl/game_sequencer.sv
// Frogger game-state sequencer: IDLE/PLAY/HIT/WIN/OVER with lives, level and tick-timed freeze.
// State, pulses and enables update one clock after the causing input; inputs are sampled levels/strobes, no backpressure.
module game_sequencer #(
    parameter int FREEZE_TICKS = 30,
    parameter int START_LIVES  = 3,
    parameter int MAX_LEVEL    = 9
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Tick,
    input  logic       i_Collision,
    input  logic       i_Frog_At_Top,
    input  logic       i_Start,
    input  logic       i_Restart,
    output logic [2:0] o_State,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Car_Enable,
    output logic       o_Frog_Enable,
    output logic       o_Reset_Frog,
    output logic       o_Level_Up,
    output logic       o_Game_Over
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd1;
    localparam logic [2:0] ST_HIT  = 3'd2;
    localparam logic [2:0] ST_WIN  = 3'd3;
    localparam logic [2:0] ST_OVER = 3'd4;

    localparam int             CNT_W      = $clog2(FREEZE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FREEZE_TICKS - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0]     LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [3:0]     LEVEL_INIT = 4'd1;

    logic [2:0]       state, state_nxt;
    logic [1:0]       lives, lives_nxt;
    logic [3:0]       level, level_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             reset_frog_nxt, level_up_nxt;
    logic             start_prev, start_armed;
    logic             start_edge;
    logic             freeze_done;

    // start_armed stays low until i_Start is seen low, so a button held through reset never starts a game.
    assign start_edge  = i_Start && !start_prev && start_armed;
    assign freeze_done = i_Tick && (cnt == CNT_LAST);

    always_comb begin
        state_nxt      = state;
        lives_nxt      = lives;
        level_nxt      = level;
        cnt_nxt        = cnt;
        reset_frog_nxt = 1'b0;
        level_up_nxt   = 1'b0;
        if (i_Restart) begin
            state_nxt = ST_IDLE;
            lives_nxt = LIVES_INIT;
            level_nxt = LEVEL_INIT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lives_nxt = LIVES_INIT;
                    level_nxt = LEVEL_INIT;
                    if (start_edge) begin
                        state_nxt      = ST_PLAY;
                        reset_frog_nxt = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (i_Collision) begin
                        state_nxt = ST_HIT;
                        cnt_nxt   = '0;
                        if (lives != 2'd0) lives_nxt = lives - 2'd1;
                    end else if (i_Frog_At_Top) begin
                        state_nxt = ST_WIN;
                        cnt_nxt   = '0;
                        if (level < LEVEL_MAX) begin
                            level_nxt    = level + 4'd1;
                            level_up_nxt = 1'b1;
                        end
                    end
                end
                ST_HIT: begin
                    if (freeze_done) begin
                        cnt_nxt = '0;
                        if (lives == 2'd0) begin
                            state_nxt = ST_OVER;
                        end else begin
                            state_nxt      = ST_PLAY;
                            reset_frog_nxt = 1'b1;
                        end
                    end else if (i_Tick) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_WIN: begin
                    if (freeze_done) begin
                        cnt_nxt        = '0;
                        state_nxt      = ST_PLAY;
                        reset_frog_nxt = 1'b1;
                    end else if (i_Tick) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_OVER: begin
                    if (start_edge) begin
                        state_nxt = ST_IDLE;
                        lives_nxt = LIVES_INIT;
                        level_nxt = LEVEL_INIT;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    lives_nxt = LIVES_INIT;
                    level_nxt = LEVEL_INIT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= ST_IDLE;
            lives        <= LIVES_INIT;
            level        <= LEVEL_INIT;
            cnt          <= '0;
            start_prev   <= 1'b0;
            start_armed  <= 1'b0;
            o_Reset_Frog <= 1'b0;
            o_Level_Up   <= 1'b0;
        end else begin
            state        <= state_nxt;
            lives        <= lives_nxt;
            level        <= level_nxt;
            cnt          <= cnt_nxt;
            start_prev   <= i_Start;
            start_armed  <= start_armed || !i_Start;
            o_Reset_Frog <= reset_frog_nxt;
            o_Level_Up   <= level_up_nxt;
        end
    end

    assign o_State       = state;
    assign o_Lives       = lives;
    assign o_Level       = level;
    assign o_Car_Enable  = (state == ST_PLAY);
    assign o_Frog_Enable = (state == ST_PLAY);
    assign o_Game_Over   = (state == ST_OVER);

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected output events, a monitor pops them on each state change or pulse.
module tb_game_sequencer;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lives;
        logic [3:0] lvl;
        logic       rf;
        logic       lu;
        logic       go;
        logic       ce;
        logic       fe;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       tick, coll, top, start, restart;
    logic [2:0] st;
    logic [1:0] lives;
    logic [3:0] lvl;
    logic       car_en, frog_en, reset_frog, level_up, game_over;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    game_sequencer dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Tick        (tick),
        .i_Collision   (coll),
        .i_Frog_At_Top (top),
        .i_Start       (start),
        .i_Restart     (restart),
        .o_State       (st),
        .o_Lives       (lives),
        .o_Level       (lvl),
        .o_Car_Enable  (car_en),
        .o_Frog_Enable (frog_en),
        .o_Reset_Frog  (reset_frog),
        .o_Level_Up    (level_up),
        .o_Game_Over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ev_t mk(input int s, input int l, input int v, input int rf, input int lu);
        ev_t e;
        e.st    = 3'(s);
        e.lives = 2'(l);
        e.lvl   = 4'(v);
        e.rf    = rf[0];
        e.lu    = lu[0];
        e.go    = (s == 4);
        e.ce    = (s == 1);
        e.fe    = (s == 1);
        return e;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("st=%0d lives=%0d lvl=%0d rf=%0b lu=%0b go=%0b ce=%0b fe=%0b",
                         e.st, e.lives, e.lvl, e.rf, e.lu, e.go, e.ce, e.fe);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic push(input int s, input int l, input int v, input int rf, input int lu);
        exp_q.push_back(mk(s, l, v, rf, lu));
    endtask

    task automatic start_edge_once();
        @(negedge clk) start = 1'b1;
        cyc(2);
        start = 1'b0;
        cyc(1);
    endtask

    // Monitor: any state change or pulse is an output event and must match the queue head.
    initial begin
        logic [2:0] prev_st;
        ev_t        act, e;
        prev_st = 3'd0;
        forever begin
            @(negedge clk);
            act = '{st: st, lives: lives, lvl: lvl, rf: reset_frog, lu: level_up,
                    go: game_over, ce: car_en, fe: frog_en};
            if (act.st != prev_st || act.rf || act.lu) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %s required none", fmt(act));
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL event: got %s required %s", fmt(act), fmt(e));
                    end
                end
            end
            prev_st = act.st;
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; coll = 1'b0; top = 1'b0; start = 1'b0; restart = 1'b0;
        cyc(2);
        chk("reset_state", int'(st), 0);
        chk("reset_lives", int'(lives), 3);
        chk("reset_level", int'(lvl), 1);
        chk("reset_rf", int'(reset_frog), 0);
        chk("reset_lu", int'(level_up), 0);
        chk("reset_car_en", int'(car_en), 0);
        chk("reset_frog_en", int'(frog_en), 0);
        chk("reset_game_over", int'(game_over), 0);
        rst = 1'b0;
        cyc(2);

        // Start from IDLE.
        push(1, 3, 1, 1, 0);
        start_edge_once();
        cyc(3);

        // First hit: the tick in the entry cycle must not count.
        push(2, 2, 1, 0, 0);
        @(negedge clk) begin coll = 1'b1; tick = 1'b1; end
        @(negedge clk) begin coll = 1'b0; tick = 1'b0; end
        ticks(29);
        push(1, 2, 1, 1, 0);
        ticks(1);
        cyc(2);

        // Collision and goal together: collision wins.
        push(2, 1, 1, 0, 0);
        @(negedge clk) begin coll = 1'b1; top = 1'b1; end
        @(negedge clk) begin coll = 1'b0; top = 1'b0; end
        ticks(29);
        push(1, 1, 1, 1, 0);
        ticks(1);
        cyc(2);

        // Last life: HIT exits to OVER with no frog reset.
        push(2, 0, 1, 0, 0);
        @(negedge clk) coll = 1'b1;
        @(negedge clk) coll = 1'b0;
        ticks(29);
        push(4, 0, 1, 0, 0);
        ticks(1);
        @(negedge clk) begin coll = 1'b1; top = 1'b1; end
        @(negedge clk) begin coll = 1'b0; top = 1'b0; end
        ticks(3);
        chk("over_lives", int'(lives), 0);

        // OVER -> IDLE on a held start (one event), then a fresh edge -> PLAY.
        push(0, 3, 1, 0, 0);
        @(negedge clk) start = 1'b1;
        cyc(4);
        start = 1'b0;
        cyc(2);
        push(1, 3, 1, 1, 0);
        start_edge_once();
        cyc(2);

        // Eight level-ups, then a ninth goal that saturates.
        for (int k = 1; k <= 9; k++) begin
            int nl;
            nl = (k < 9) ? k + 1 : 9;
            push(3, 3, nl, 0, (k < 9) ? 1 : 0);
            @(negedge clk) top = 1'b1;
            @(negedge clk) top = 1'b0;
            ticks(29);
            push(1, 3, nl, 1, 0);
            ticks(1);
            cyc(1);
        end
        chk("saturated_level", int'(lvl), 9);

        // Restart at tick 15 of a HIT.
        push(2, 2, 9, 0, 0);
        @(negedge clk) coll = 1'b1;
        @(negedge clk) coll = 1'b0;
        ticks(15);
        push(0, 3, 1, 0, 0);
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        ticks(20);
        chk("restart_lives", int'(lives), 3);
        chk("restart_level", int'(lvl), 1);

        // Reset mid-WIN with start held: stay IDLE until start re-edges.
        push(1, 3, 1, 1, 0);
        start_edge_once();
        push(3, 3, 2, 0, 1);
        @(negedge clk) top = 1'b1;
        @(negedge clk) top = 1'b0;
        ticks(10);
        @(negedge clk) start = 1'b1;
        cyc(2);
        push(0, 3, 1, 0, 0);
        #2 rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        ticks(25);
        chk("post_reset_idle", int'(st), 0);
        start = 1'b0;
        cyc(2);
        push(1, 3, 1, 1, 0);
        start_edge_once();
        cyc(2);

        // Restart overrides a simultaneous goal reach in PLAY.
        push(0, 3, 1, 0, 0);
        @(negedge clk) begin restart = 1'b1; top = 1'b1; end
        @(negedge clk) begin restart = 1'b0; top = 1'b0; end
        cyc(4);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter FREEZE_TICKS, default 30: number of i_Tick pulses spent in HIT or WIN before leaving.
REQ-002 SHALL have parameter START_LIVES, default 3: lives loaded on reset and on entry to IDLE (range 1..3).
REQ-003 SHALL have parameter MAX_LEVEL, default 9: level saturation value (range 1..15).
REQ-004 SHALL have port i_Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_Tick, input, 1 bit: one-cycle frame/timebase strobe.
REQ-007 SHALL have port i_Collision, input, 1 bit: level; frog overlaps a car.
REQ-008 SHALL have port i_Frog_At_Top, input, 1 bit: level; frog reached the goal row.
REQ-009 SHALL have port i_Start, input, 1 bit: level; debounced start button.
REQ-010 SHALL have port i_Restart, input, 1 bit: level; all four switches held.
REQ-011 SHALL have port o_State, output, 3 bits: IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4.
REQ-012 SHALL have port o_Lives, output, 2 bits: remaining lives.
REQ-013 SHALL have port o_Level, output, 4 bits: current level.
REQ-014 SHALL have port o_Car_Enable, output, 1 bit: cars may move.
REQ-015 SHALL have port o_Frog_Enable, output, 1 bit: frog input accepted.
REQ-016 SHALL have port o_Reset_Frog, output, 1 bit: one-cycle pulse; return frog to start.
REQ-017 SHALL have port o_Level_Up, output, 1 bit: one-cycle pulse on level increment.
REQ-018 SHALL have port o_Game_Over, output, 1 bit: high exactly while in OVER.

Function
REQ-019 SHALL detect an i_Start rising edge internally via a registered previous value; a held i_Start SHALL count as one event.
REQ-020 SHALL decode o_Car_Enable and o_Frog_Enable high only in PLAY; o_Game_Over high only in OVER; all three SHALL be registered or state-decoded with no input-to-output combinational path.
REQ-021 IDLE: lives=START_LIVES, level=1; on i_Start edge -> PLAY, o_Reset_Frog pulsed in the transition cycle.
REQ-022 PLAY: i_Collision -> HIT with lives decremented by 1 on the transition edge; otherwise i_Frog_At_Top -> WIN.
REQ-023 When i_Collision and i_Frog_At_Top are both high in PLAY, collision SHALL win: -> HIT, no level change.
REQ-024 On entry to WIN, level SHALL increment and o_Level_Up SHALL pulse one cycle; at level==MAX_LEVEL level SHALL hold, no pulse, WIN still entered.
REQ-025 HIT and WIN: the freeze counter SHALL clear on entry and count i_Tick pulses; an i_Tick in the entry cycle SHALL NOT be counted.
REQ-026 On the cycle the FREEZE_TICKS-th tick is counted: from WIN -> PLAY; from HIT -> OVER if lives==0, else -> PLAY; each -> PLAY transition SHALL pulse o_Reset_Frog.
REQ-027 i_Collision and i_Frog_At_Top SHALL be ignored outside PLAY.
REQ-028 o_Lives SHALL never underflow; decrement occurs only on the PLAY->HIT edge.
REQ-029 OVER: lives and level frozen; on i_Start edge -> IDLE, reloading lives and level.
REQ-030 i_Restart high SHALL force -> IDLE on the next edge from any state, overriding every other transition, and SHALL clear the freeze counter; no o_Reset_Frog or o_Level_Up pulse in that cycle.
REQ-031 Unused encodings 5..7 SHALL return to IDLE on the next edge.

Reset
REQ-032 While i_Reset is high, asynchronously: state=IDLE, o_Lives=START_LIVES, o_Level=1, freeze counter=0, start edge register=0, all pulse and enable outputs=0.
REQ-033 After i_Reset deasserts with i_Start already high, the block SHALL NOT start until i_Start falls and rises again.
REQ-034 Reset asserted mid-HIT or mid-WIN SHALL abandon the freeze with no trailing pulse.

Verification
REQ-035 Reset, i_Start edge -> o_State 0->1, o_Reset_Frog one cycle, o_Lives=3, o_Level=1, o_Car_Enable=1.
REQ-036 PLAY, three collisions, each followed by 30 ticks -> lives 2,1,0; third HIT exits to OVER after 30th tick, o_Game_Over=1, no o_Reset_Frog.
REQ-037 PLAY, i_Collision and i_Frog_At_Top high same cycle -> HIT, o_Lives=2, o_Level=1, no o_Level_Up.
REQ-038 Eight goal reaches from level 1 -> o_Level=9 with 8 o_Level_Up pulses; ninth reach -> WIN entered, level 9, no pulse, returns to PLAY after 30 ticks.
REQ-039 i_Restart at tick 15 of HIT -> IDLE next edge, o_Lives=3, o_Level=1, no pulses.
REQ-040 i_Reset pulsed mid-WIN with i_Start held high -> IDLE immediately; stays IDLE until i_Start re-edges.
